cool_heat_system: RTL and testbench

COOL_HEAT_SYSTEM -- requirements
Module: cool_heat_system

---
 rtl/cool_heat_pkg.sv | 25 ++
 rtl/chs_pwm.sv | 31 +++
 rtl/cool_heat_system.sv | 112 +++++++++++
 tb/tb_cool_heat_system.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/cool_heat_pkg.sv
// cool_heat_pkg: shared FSM state encoding, configuration bit positions and target helper
//   chs_state_t  : OFF / RAMP_UP / RUN / RAMP_DOWN
//   CONF_*       : bit positions inside chs_conf
//   eff_target() : requested level, forced to 0 when disabled or when the mode request differs
package cool_heat_pkg;

    typedef enum logic [1:0] {
        ST_OFF       = 2'd0,
        ST_RAMP_UP   = 2'd1,
        ST_RUN       = 2'd2,
        ST_RAMP_DOWN = 2'd3
    } chs_state_t;

    localparam int CONF_MODE    = 7;
    localparam int CONF_EN      = 5;
    localparam int CONF_LVL_MSB = 3;
    localparam int CONF_LVL_LSB = 0;

    localparam logic [3:0] PWR_MAX = 4'd15;

    function automatic logic [3:0] eff_target(input logic [7:0] conf, input logic mode);
        return (conf[CONF_EN] && conf[CONF_MODE] == mode) ? conf[CONF_LVL_MSB:CONF_LVL_LSB] : 4'd0;
    endfunction

endpackage

// File: rtl/chs_pwm.sv
// chs_pwm: free-running 8-bit period counter with registered PWM comparator
//   clk        : clock
//   arst       : synchronous active-low reset
//   speed      : duty request, high for speed cycles out of 256
//   enable     : gates the PWM output (power level non-zero)
//   pwm_data   : registered PWM drive
//   period_end : high in the cycle the counter sits at 255
module chs_pwm (
    input  logic       clk,
    input  logic       arst,
    input  logic [7:0] speed,
    input  logic       enable,
    output logic       pwm_data,
    output logic       period_end
);

    logic [7:0] r_cnt;

    assign period_end = (r_cnt == 8'hFF);

    always_ff @(posedge clk) begin
        if (!arst) begin
            r_cnt    <= '0;
            pwm_data <= 1'b0;
        end else begin
            r_cnt    <= r_cnt + 8'd1;
            pwm_data <= (r_cnt < speed) && enable;
        end
    end

endmodule

// File: rtl/cool_heat_system.sv
// cool_heat_system: cool/heat power controller with ramped power level and PWM drive
//   clk       : clock
//   arst      : synchronous active-low reset
//   speed     : PWM duty request (speed/256)
//   chs_conf  : [7] mode request (1=cool), [5] enable, [3:0] target level
//   chs_power : applied power level 0..15
//   chs_mode  : operating mode (1=cool, 0=heat)
//   pwm_data  : PWM drive signal
module cool_heat_system
    import cool_heat_pkg::*;
#(
    parameter int RAMP_PERIODS = 1
) (
    input  logic       clk,
    input  logic       arst,
    input  logic [7:0] speed,
    input  logic [7:0] chs_conf,
    output logic [3:0] chs_power,
    output logic       chs_mode,
    output logic       pwm_data
);

    chs_state_t r_state, w_state_nxt;
    logic [3:0] r_power, w_power_nxt;
    logic       r_mode, w_mode_nxt;
    logic [3:0] r_ramp_cnt;
    logic [3:0] w_tgt;
    logic       w_period_end;
    logic       w_step;
    logic       w_unused;

    assign w_unused  = ^{chs_conf[6], chs_conf[4]};
    assign w_tgt     = eff_target(chs_conf, r_mode);
    assign w_step    = w_period_end && (r_ramp_cnt == 4'(RAMP_PERIODS - 1));
    assign chs_power = r_power;
    assign chs_mode  = r_mode;

    chs_pwm u_pwm (
        .clk        (clk),
        .arst       (arst),
        .speed      (speed),
        .enable     (r_power != 4'd0),
        .pwm_data   (pwm_data),
        .period_end (w_period_end)
    );

    // Every branch re-reads the live effective target, so config changes mid-ramp
    // redirect the ramp on the next cycle. Steps only move toward the target,
    // which keeps power inside 0..15 without wrapping.
    always_comb begin
        w_state_nxt = r_state;
        w_power_nxt = r_power;
        w_mode_nxt  = r_mode;
        case (r_state)
            ST_OFF: begin
                w_power_nxt = 4'd0;
                w_mode_nxt  = chs_conf[CONF_MODE];
                if (chs_conf[CONF_EN] && chs_conf[CONF_LVL_MSB:CONF_LVL_LSB] != 4'd0)
                    w_state_nxt = ST_RAMP_UP;
            end
            ST_RAMP_UP: begin
                if (w_tgt < r_power)
                    w_state_nxt = ST_RAMP_DOWN;
                else if (w_tgt == r_power)
                    w_state_nxt = (r_power == 4'd0) ? ST_OFF : ST_RUN;
                else if (w_step && r_power != PWR_MAX)
                    w_power_nxt = r_power + 4'd1;
            end
            ST_RUN: begin
                if (w_tgt > r_power)
                    w_state_nxt = ST_RAMP_UP;
                else if (w_tgt < r_power)
                    w_state_nxt = ST_RAMP_DOWN;
            end
            ST_RAMP_DOWN: begin
                if (r_power == 4'd0)
                    w_state_nxt = ST_OFF;
                else if (w_tgt == r_power)
                    w_state_nxt = ST_RUN;
                else if (w_tgt > r_power)
                    w_state_nxt = ST_RAMP_UP;
                else if (w_step)
                    w_power_nxt = r_power - 4'd1;
            end
            default: w_state_nxt = ST_OFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!arst) begin
            r_state <= ST_OFF;
            r_power <= 4'd0;
            r_mode  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_power <= w_power_nxt;
            r_mode  <= w_mode_nxt;
        end
    end

    // Cleared on every state change so the first step after a transition
    // waits a full RAMP_PERIODS periods.
    always_ff @(posedge clk) begin
        if (!arst)
            r_ramp_cnt <= 4'd0;
        else if (w_state_nxt != r_state || w_step)
            r_ramp_cnt <= 4'd0;
        else if (w_period_end)
            r_ramp_cnt <= r_ramp_cnt + 4'd1;
    end

endmodule

// File: tb/tb_cool_heat_system.sv
// tb_cool_heat_system: directed self-checking bench for cool_heat_system
module tb_cool_heat_system;

    logic       clk = 1'b0;
    logic       arst = 1'b0;
    logic [7:0] speed = 8'h00;
    logic [7:0] chs_conf = 8'h00;
    logic [3:0] chs_power;
    logic       chs_mode;
    logic       pwm_data;

    int n_pass = 0;
    int n_total = 0;
    int e = 0;

    cool_heat_system #(.RAMP_PERIODS(1)) dut (
        .clk       (clk),
        .arst      (arst),
        .speed     (speed),
        .chs_conf  (chs_conf),
        .chs_power (chs_power),
        .chs_mode  (chs_mode),
        .pwm_data  (pwm_data)
    );

    always #5 clk = ~clk;

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached at edge %0d", e);
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
        e++;
    endtask

    task automatic tick_to(input int n);
        while (e < n) tick();
    endtask

    task automatic test_reset;
        arst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            speed    = 8'($urandom);
            chs_conf = 8'($urandom);
            tick();
            n_total++;
            if ({chs_power, chs_mode, pwm_data} !== 6'd0)
                $display("FAIL reset_%0d: power=%0d mode=%0b pwm=%0b expected all 0", i, chs_power, chs_mode, pwm_data);
            else n_pass++;
        end
        speed    = 8'h40;
        chs_conf = 8'hAA;
        arst     = 1'b1;
        e        = 0;
    endtask

    task automatic test_ramp_up;
        tick();
        n_total++;
        if (chs_mode !== 1'b1 || chs_power !== 4'd0)
            $display("FAIL first_edge: mode=%0b power=%0d expected mode=1 power=0", chs_mode, chs_power);
        else n_pass++;
        tick_to(100);
        n_total++;
        if (pwm_data !== 1'b0)
            $display("FAIL pwm_at_power0: pwm=%0b expected 0", pwm_data);
        else n_pass++;
        for (int k = 1; k <= 10; k++) begin
            tick_to(256 * k - 1);
            n_total++;
            if (chs_power !== 4'(k - 1))
                $display("FAIL ramp_pre_%0d: power=%0d expected %0d", k, chs_power, k - 1);
            else n_pass++;
            tick();
            n_total++;
            if (chs_power !== 4'(k))
                $display("FAIL ramp_step_%0d: power=%0d expected %0d", k, chs_power, k);
            else n_pass++;
        end
        tick_to(2816);
        n_total++;
        if (chs_power !== 4'd10 || chs_mode !== 1'b1)
            $display("FAIL run_hold: power=%0d mode=%0b expected 10/1", chs_power, chs_mode);
        else n_pass++;
    endtask

    task automatic test_pwm;
        int hi;
        logic [7:0] sp [3] = '{8'h40, 8'h00, 8'hFF};
        int exp_hi [3] = '{64, 0, 255};
        for (int j = 0; j < 3; j++) begin
            speed = sp[j];
            hi = 0;
            for (int i = 1; i <= 256; i++) begin
                tick();
                if (pwm_data === 1'b1) hi++;
            end
            n_total++;
            if (hi !== exp_hi[j])
                $display("FAIL duty_%02h: high=%0d expected %0d", sp[j], hi, exp_hi[j]);
            else n_pass++;
        end
        speed = 8'h40;
        tick_to(3584 + 1);
        n_total++;
        if (pwm_data !== 1'b1)
            $display("FAIL pwm_start: pwm=%0b expected 1", pwm_data);
        else n_pass++;
        tick_to(3584 + 64);
        n_total++;
        if (pwm_data !== 1'b1)
            $display("FAIL pwm_last_high: pwm=%0b expected 1", pwm_data);
        else n_pass++;
        tick_to(3584 + 65);
        n_total++;
        if (pwm_data !== 1'b0)
            $display("FAIL pwm_first_low: pwm=%0b expected 0", pwm_data);
        else n_pass++;
        tick_to(3584 + 100);
        speed = 8'h80;
        tick();
        n_total++;
        if (pwm_data !== 1'b1)
            $display("FAIL speed_immediate: pwm=%0b expected 1", pwm_data);
        else n_pass++;
        speed = 8'h40;
        tick_to(4096);
    endtask

    task automatic test_mode_reversal;
        int b;
        b = e;
        chs_conf = 8'h2A;
        tick_to(b + 255);
        n_total++;
        if (chs_power !== 4'd10)
            $display("FAIL rev_hold: power=%0d expected 10", chs_power);
        else n_pass++;
        tick();
        n_total++;
        if (chs_power !== 4'd9)
            $display("FAIL rev_first_down: power=%0d expected 9", chs_power);
        else n_pass++;
        tick_to(b + 2560);
        n_total++;
        if (chs_power !== 4'd0 || chs_mode !== 1'b1)
            $display("FAIL rev_zero: power=%0d mode=%0b expected 0/1", chs_power, chs_mode);
        else n_pass++;
        tick();
        n_total++;
        if (chs_mode !== 1'b1 || pwm_data !== 1'b0)
            $display("FAIL rev_enter_off: mode=%0b pwm=%0b expected 1/0", chs_mode, pwm_data);
        else n_pass++;
        tick();
        n_total++;
        if (chs_mode !== 1'b0 || chs_power !== 4'd0)
            $display("FAIL rev_mode_flip: mode=%0b power=%0d expected 0/0", chs_mode, chs_power);
        else n_pass++;
        tick_to(b + 2816);
        n_total++;
        if (chs_power !== 4'd1)
            $display("FAIL rev_up_1: power=%0d expected 1", chs_power);
        else n_pass++;
        tick_to(b + 5120);
        n_total++;
        if (chs_power !== 4'd10 || chs_mode !== 1'b0)
            $display("FAIL rev_up_10: power=%0d mode=%0b expected 10/0", chs_power, chs_mode);
        else n_pass++;
        tick_to(b + 5376);
    endtask

    task automatic test_disable;
        int b;
        b = e;
        chs_conf = 8'h8A;
        tick_to(b + 256);
        n_total++;
        if (chs_power !== 4'd9)
            $display("FAIL dis_first_down: power=%0d expected 9", chs_power);
        else n_pass++;
        tick_to(b + 2560);
        n_total++;
        if (chs_power !== 4'd0)
            $display("FAIL dis_zero: power=%0d expected 0", chs_power);
        else n_pass++;
        tick_to(b + 2816);
        n_total++;
        if (chs_power !== 4'd0 || chs_mode !== 1'b1 || pwm_data !== 1'b0)
            $display("FAIL dis_off: power=%0d mode=%0b pwm=%0b expected 0/1/0", chs_power, chs_mode, pwm_data);
        else n_pass++;
    endtask

    task automatic test_reset_mid_ramp;
        int b;
        b = e;
        chs_conf = 8'hAA;
        tick_to(b + 1300);
        n_total++;
        if (chs_power !== 4'd5)
            $display("FAIL mid_ramp_level: power=%0d expected 5", chs_power);
        else n_pass++;
        arst = 1'b0;
        tick();
        n_total++;
        if ({chs_power, chs_mode, pwm_data} !== 6'd0)
            $display("FAIL mid_ramp_reset: power=%0d mode=%0b pwm=%0b expected all 0", chs_power, chs_mode, pwm_data);
        else n_pass++;
        arst = 1'b1;
        tick();
        n_total++;
        if (chs_power !== 4'd0 || chs_mode !== 1'b1)
            $display("FAIL post_reset: power=%0d mode=%0b expected 0/1", chs_power, chs_mode);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_pwm();
        test_mode_reversal();
        test_disable();
        test_reset_mid_ramp();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
